issueque_int: RTL

- Integer issue queue. It is the receiving end of the dispatch-to-execution-queue interface (equeue_* common bus plus the equeueint_en/equeueint_ready handshake).
- Holds up to DEPTH dispatched integer instructions and snoops the CDB to wake up pending source operands.
- Each cycle it offers the oldest entry whose operands are both valid to the integer issue unit, and removes that entry on grant.
- Queue is collapsing: index 0 is always the oldest entry.

---
 rtl/issueque_int_if.sv | 52 +++++
 rtl/issueque_int.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/issueque_int_if.sv
// Dispatch, CDB and issue signals of the integer issue queue.
// The slave modport is the queue side; master is the dispatch/CDB/issue-unit side.
interface issueque_int_if #(
    parameter int TAGW = 6
);
    logic [15:0]     equeue_imm;
    logic [TAGW-1:0] equeue_rdtag;
    logic [TAGW-1:0] equeue_rstag;
    logic [TAGW-1:0] equeue_rttag;
    logic [31:0]     equeue_rsdata;
    logic [31:0]     equeue_rtdata;
    logic            equeue_rsvalid;
    logic            equeue_rtvalid;
    logic [2:0]      equeueint_opcode;
    logic            equeueint_en;
    logic            equeueint_ready;
    logic [TAGW-1:0] cdb_tag;
    logic [31:0]     cdb_data;
    logic            cdb_valid;
    logic            issue_req;
    logic            issue_grant;
    logic [2:0]      issue_opcode;
    logic [31:0]     issue_rsdata;
    logic [31:0]     issue_rtdata;
    logic [TAGW-1:0] issue_rdtag;
    logic [15:0]     issue_imm;
    logic [3:0]      count;

    modport slave (
        input  equeue_imm, equeue_rdtag, equeue_rstag, equeue_rttag,
        input  equeue_rsdata, equeue_rtdata, equeue_rsvalid, equeue_rtvalid,
        input  equeueint_opcode, equeueint_en,
        output equeueint_ready,
        input  cdb_tag, cdb_data, cdb_valid,
        output issue_req,
        input  issue_grant,
        output issue_opcode, issue_rsdata, issue_rtdata, issue_rdtag, issue_imm,
        output count
    );

    modport master (
        output equeue_imm, equeue_rdtag, equeue_rstag, equeue_rttag,
        output equeue_rsdata, equeue_rtdata, equeue_rsvalid, equeue_rtvalid,
        output equeueint_opcode, equeueint_en,
        input  equeueint_ready,
        output cdb_tag, cdb_data, cdb_valid,
        input  issue_req,
        output issue_grant,
        input  issue_opcode, issue_rsdata, issue_rtdata, issue_rdtag, issue_imm,
        input  count
    );
endinterface

// File: rtl/issueque_int.sv
// Collapsing integer issue queue: index 0 is oldest, operands wake from the CDB,
// and the oldest fully-ready entry is offered to the issue unit each cycle.
module issueque_int #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 6
) (
    input  logic           clk,
    input  logic           reset,
    issueque_int_if.slave  bus
);
    typedef struct packed {
        logic            valid;
        logic [2:0]      opcode;
        logic [TAGW-1:0] rdtag;
        logic [15:0]     imm;
        logic [TAGW-1:0] rstag;
        logic [31:0]     rsdata;
        logic            rsvalid;
        logic [TAGW-1:0] rttag;
        logic [31:0]     rtdata;
        logic            rtvalid;
    } entry_t;

    entry_t     ent_q [DEPTH];
    entry_t     ent_d [DEPTH];
    entry_t     woken [DEPTH+1];
    entry_t     incoming;
    logic [3:0] count_q;
    logic [3:0] count_d;
    logic [3:0] sel_idx;
    logic [3:0] wr_idx;
    logic       sel_found;
    logic       ready;
    logic       do_issue;
    logic       do_write;

    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] rs_hit;
    logic [DEPTH-1:0] rt_hit;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign rdy[gi]    = ent_q[gi].valid & ent_q[gi].rsvalid & ent_q[gi].rtvalid;
            assign rs_hit[gi] = ent_q[gi].valid & ~ent_q[gi].rsvalid & bus.cdb_valid &
                                (ent_q[gi].rstag == bus.cdb_tag);
            assign rt_hit[gi] = ent_q[gi].valid & ~ent_q[gi].rtvalid & bus.cdb_valid &
                                (ent_q[gi].rttag == bus.cdb_tag);
        end
    endgenerate

    assign ready                = (count_q < 4'(DEPTH));
    assign bus.equeueint_ready  = ready;
    assign bus.count            = count_q;

    // Selection looks only at registered readiness, so a fresh wakeup waits a cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                sel_found = 1'b1;
                sel_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        bus.issue_req    = sel_found;
        bus.issue_opcode = '0;
        bus.issue_rsdata = '0;
        bus.issue_rtdata = '0;
        bus.issue_rdtag  = '0;
        bus.issue_imm    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_found && sel_idx == 4'(i)) begin
                bus.issue_opcode = ent_q[i].opcode;
                bus.issue_rsdata = ent_q[i].rsdata;
                bus.issue_rtdata = ent_q[i].rtdata;
                bus.issue_rdtag  = ent_q[i].rdtag;
                bus.issue_imm    = ent_q[i].imm;
            end
        end
    end

    assign do_issue = sel_found & bus.issue_grant;
    assign do_write = bus.equeueint_en & ready;
    assign wr_idx   = do_issue ? (count_q - 4'd1) : count_q;

    always_comb begin
        incoming         = '0;
        incoming.valid   = 1'b1;
        incoming.opcode  = bus.equeueint_opcode;
        incoming.rdtag   = bus.equeue_rdtag;
        incoming.imm     = bus.equeue_imm;
        incoming.rstag   = bus.equeue_rstag;
        incoming.rsdata  = bus.equeue_rsdata;
        incoming.rsvalid = bus.equeue_rsvalid;
        incoming.rttag   = bus.equeue_rttag;
        incoming.rtdata  = bus.equeue_rtdata;
        incoming.rtvalid = bus.equeue_rtvalid;
        if (!bus.equeue_rsvalid && bus.cdb_valid && bus.equeue_rstag == bus.cdb_tag) begin
            incoming.rsdata  = bus.cdb_data;
            incoming.rsvalid = 1'b1;
        end
        if (!bus.equeue_rtvalid && bus.cdb_valid && bus.equeue_rttag == bus.cdb_tag) begin
            incoming.rtdata  = bus.cdb_data;
            incoming.rtvalid = 1'b1;
        end
    end

    // Wakeup first, then collapse over the removed slot, then place the new entry.
    always_comb begin
        woken[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = ent_q[i];
            if (rs_hit[i]) begin
                woken[i].rsdata  = bus.cdb_data;
                woken[i].rsvalid = 1'b1;
            end
            if (rt_hit[i]) begin
                woken[i].rtdata  = bus.cdb_data;
                woken[i].rtvalid = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = (do_issue && 4'(i) >= sel_idx) ? woken[i+1] : woken[i];
            if (do_write && wr_idx == 4'(i)) begin
                ent_d[i] = incoming;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (do_write && !do_issue) begin
            count_d = count_q + 4'd1;
        end else if (do_issue && !do_write) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end
endmodule
